// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the floating-point unit arbiter.
package fp_arb_pkg;

    localparam int unsigned NREQ_DFLT = 4;
    localparam int unsigned ID_W      = (NREQ_DFLT > 1) ? $clog2(NREQ_DFLT) : 1;

    // Owner tag carried alongside each in-flight operation
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    localparam logic [31:0] ONE   = 32'h3F80_0000;
    localparam logic [31:0] TWO   = 32'h4000_0000;
    localparam logic [31:0] THREE = 32'h4040_0000;

endpackage

// File: rtl/fp_unit_arbiter_rr_arbiter.sv
// Round-robin pick: first request at or after the pointer wins.
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DFLT
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt_c,
    output logic [ID_W-1:0] ptr_next_c
);

    // Circular scan from ptr; next pointer lands just past the winner
    always_comb begin
        logic            found;
        logic [ID_W-1:0] idx;
        gnt_c      = '0;
        ptr_next_c = ptr;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ID_W'((32'(ptr) + 32'(k)) % NREQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_c[idx] = 1'b1;
                ptr_next_c = ID_W'((32'(idx) + 32'd1) % NREQ);
            end
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one pipelined FP core among NREQ requesters and routes results back.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DFLT,
    parameter int unsigned W    = 32,
    parameter int unsigned LAT  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ*W-1:0]             opa_in,
    input  logic [NREQ*W-1:0]             opb_in,
    output logic [NREQ-1:0]               gnt,
    output logic [W-1:0]                  unit_a,
    output logic [W-1:0]                  unit_b,
    input  logic [W-1:0]                  unit_result,
    output logic [NREQ-1:0]               rsp_valid,
    output logic [W-1:0]                  rsp_data,
    output logic [$clog2(LAT+2):0]        inflight,
    output logic                          idle
);

    localparam int unsigned CNT_W = $clog2(LAT + 2) + 1;

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_next_c;
    logic [NREQ-1:0] gnt_raw_c;
    logic [ID_W-1:0] gnt_id_c;
    logic            grant_any_c;
    logic            rsp_any_c;
    tag_t            tag_q [LAT+1];
    tag_t            tag_out_c;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (req),
        .ptr        (ptr_q),
        .gnt_c      (gnt_raw_c),
        .ptr_next_c (ptr_next_c)
    );

    // Grant is suppressed while reset is held
    assign gnt         = rst ? gnt_raw_c : '0;
    assign grant_any_c = |gnt;
    assign rsp_any_c   = |rsp_valid;
    assign tag_out_c   = tag_q[LAT];
    assign idle        = (inflight == '0) && !(|req);

    // One-hot grant to requester index
    always_comb begin
        gnt_id_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) gnt_id_c = ID_W'(i);
        end
    end

    // Round-robin pointer advances only on a grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             ptr_q <= '0;
        else if (grant_any_c) ptr_q <= ptr_next_c;
    end

    // Core operand registers capture the winner's operands
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unit_a <= '0;
            unit_b <= '0;
        end else if (grant_any_c) begin
            unit_a <= opa_in[32'(gnt_id_c)*W +: W];
            unit_b <= opb_in[32'(gnt_id_c)*W +: W];
        end
    end

    // Owner tags shift alongside the core so the last stage meets unit_result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= '{valid: grant_any_c, id: gnt_id_c};
            for (int k = 1; k <= LAT; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    // Capture the result and pulse the owner's response bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else if (tag_out_c.valid) begin
            rsp_valid <= NREQ'(1) << tag_out_c.id;
            rsp_data  <= unit_result;
        end else begin
            rsp_valid <= '0;
        end
    end

    // Outstanding count: up on grant, down when the response pulse is out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                           inflight <= '0;
        else if (grant_any_c && !rsp_any_c) inflight <= inflight + CNT_W'(1);
        else if (!grant_any_c && rsp_any_c) inflight <= inflight - CNT_W'(1);
    end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a small integer-valued FP adder model.
module tb_fp_unit_arbiter;
    import fp_arb_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned W     = 32;
    localparam int unsigned LAT   = 8;
    localparam int unsigned CNT_W = $clog2(LAT + 2) + 1;
    localparam logic [31:0] FOUR  = 32'h4080_0000;
    localparam logic [31:0] FIVE  = 32'h40A0_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] opa_in = '0;
    logic [NREQ*W-1:0] opb_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      unit_a, unit_b, unit_result;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [CNT_W-1:0]  inflight;
    logic              idle;

    int tests_run    = 0;
    int tests_failed = 0;

    fp_unit_arbiter #(.NREQ(NREQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .opa_in(opa_in), .opb_in(opb_in),
        .gnt(gnt), .unit_a(unit_a), .unit_b(unit_b), .unit_result(unit_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .inflight(inflight), .idle(idle)
    );

    always #5 clk = ~clk;

    // Positive integer-valued floats only
    function automatic int unsigned f2i(input logic [31:0] x);
        int e;
        if (x == 32'd0) return 0;
        e = int'(x[30:23]) - 127;
        if (e < 0 || e > 23) return 0;
        return int'({1'b1, x[22:0]}) >> (23 - e);
    endfunction

    function automatic logic [31:0] i2f(input int unsigned v);
        int p;
        int unsigned frac;
        if (v == 0) return 32'd0;
        p = 0;
        for (int b = 0; b < 25; b++) if (v[b]) p = b;
        frac = (v << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(p + 127), frac[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return i2f(f2i(a) + f2i(b));
    endfunction

    // Adder core model: result for inputs seen in cycle c appears in cycle c+LAT
    logic [W-1:0] core_pipe [LAT];
    always @(posedge clk) begin
        core_pipe[0] <= fp_add(unit_a, unit_b);
        for (int k = 1; k < LAT; k++) core_pipe[k] <= core_pipe[k-1];
    end
    assign unit_result = core_pipe[LAT-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = '1;
        @(negedge clk);
        tests_run++; if (gnt !== 4'b0000) begin tests_failed++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        tests_run++; if (rsp_valid !== 4'b0000) begin tests_failed++; $display("FAIL reset_rsp_valid got %b exp 0000", rsp_valid); end
        tests_run++; if (inflight !== '0) begin tests_failed++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        tests_run++; if (unit_a !== '0 || unit_b !== '0) begin tests_failed++; $display("FAIL reset_unit got %h/%h exp 0/0", unit_a, unit_b); end
        tests_run++; if (rsp_data !== '0) begin tests_failed++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
        tick();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        tests_run++; if (idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle got %b exp 1", idle); end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] exp_v;
        do_reset();
        req = 4'b0001;
        opa_in[0 +: W] = ONE;
        opb_in[0 +: W] = TWO;
        @(negedge clk);
        tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL single_gnt got %b exp 0001", gnt); end
        tick();
        req = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                tests_run++; if (unit_a !== ONE || unit_b !== TWO) begin tests_failed++; $display("FAIL single_unit got %h/%h exp %h/%h", unit_a, unit_b, ONE, TWO); end
            end
            exp_v = (k == LAT + 2) ? 4'b0001 : 4'b0000;
            tests_run++; if (rsp_valid !== exp_v) begin tests_failed++; $display("FAIL single_rsp_valid k=%0d got %b exp %b", k, rsp_valid, exp_v); end
            if (k == LAT + 2) begin
                tests_run++; if (rsp_data !== THREE) begin tests_failed++; $display("FAIL single_rsp_data got %h exp %h", rsp_data, THREE); end
            end
            tests_run++; if (inflight !== CNT_W'((k <= LAT + 2) ? 1 : 0)) begin tests_failed++; $display("FAIL single_inflight k=%0d got %0d exp %0d", k, inflight, (k <= LAT + 2) ? 1 : 0); end
            tick();
        end
        @(negedge clk);
        tests_run++; if (idle !== 1'b1) begin tests_failed++; $display("FAIL single_idle got %b exp 1", idle); end
    endtask

    task automatic test_contention();
        logic [31:0]     exp_d [4];
        logic [NREQ-1:0] exp_g, exp_v;
        exp_d[0] = TWO; exp_d[1] = THREE; exp_d[2] = FOUR; exp_d[3] = FIVE;
        do_reset();
        opa_in = {FOUR, THREE, TWO, ONE};
        opb_in = {ONE, ONE, ONE, ONE};
        for (int c = 0; c < 16; c++) begin
            req = (c < 4) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            exp_g = (c < 4) ? 4'(1 << c) : 4'b0000;
            tests_run++; if (gnt !== exp_g) begin tests_failed++; $display("FAIL contention_gnt c=%0d got %b exp %b", c, gnt, exp_g); end
            exp_v = (c >= 10 && c < 14) ? 4'(1 << (c - 10)) : 4'b0000;
            tests_run++; if (rsp_valid !== exp_v) begin tests_failed++; $display("FAIL contention_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_v); end
            if (c >= 10 && c < 14) begin
                tests_run++; if (rsp_data !== exp_d[c-10]) begin tests_failed++; $display("FAIL contention_rsp_data c=%0d got %h exp %h", c, rsp_data, exp_d[c-10]); end
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        int n0 = 0, n2 = 0;
        logic [NREQ-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            req = 4'b0101;
            @(negedge clk);
            exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            tests_run++; if (gnt !== exp_g) begin tests_failed++; $display("FAIL fairness_gnt c=%0d got %b exp %b", c, gnt, exp_g); end
            if (gnt[0]) n0++;
            if (gnt[2]) n2++;
            tick();
        end
        req = '0;
        tests_run++; if (n0 != 5 || n2 != 5) begin tests_failed++; $display("FAIL fairness_counts got %0d/%0d exp 5/5", n0, n2); end
        repeat (12) tick();
        @(negedge clk);
        tests_run++; if (inflight !== '0 || idle !== 1'b1) begin tests_failed++; $display("FAIL fairness_drain got inflight=%0d idle=%b exp 0/1", inflight, idle); end
    endtask

    task automatic test_throughput();
        int peak = 0;
        int exp_inf;
        logic [NREQ-1:0] exp_g, exp_v;
        do_reset();
        opa_in[1*W +: W] = ONE;
        opb_in[1*W +: W] = ONE;
        for (int c = 0; c < 30; c++) begin
            req = (c < 16) ? 4'b0010 : 4'b0000;
            @(negedge clk);
            exp_g = (c < 16) ? 4'b0010 : 4'b0000;
            tests_run++; if (gnt !== exp_g) begin tests_failed++; $display("FAIL throughput_gnt c=%0d got %b exp %b", c, gnt, exp_g); end
            exp_v = (c >= 10 && c < 26) ? 4'b0010 : 4'b0000;
            tests_run++; if (rsp_valid !== exp_v) begin tests_failed++; $display("FAIL throughput_rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_v); end
            if (c >= 10 && c < 26) begin
                tests_run++; if (rsp_data !== TWO) begin tests_failed++; $display("FAIL throughput_rsp_data c=%0d got %h exp %h", c, rsp_data, TWO); end
            end
            exp_inf = ((c < 16) ? c : 16) - ((c > 26) ? 16 : ((c > 10) ? c - 10 : 0));
            tests_run++; if (inflight !== CNT_W'(exp_inf)) begin tests_failed++; $display("FAIL throughput_inflight c=%0d got %0d exp %0d", c, inflight, exp_inf); end
            if (int'(inflight) > peak) peak = int'(inflight);
            tick();
        end
        tests_run++; if (peak != LAT + 2) begin tests_failed++; $display("FAIL throughput_peak got %0d exp %0d", peak, LAT + 2); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        opa_in[3*W +: W] = TWO;
        opb_in[3*W +: W] = ONE;
        for (int c = 0; c <= 20; c++) begin
            req = 4'b1000;
            @(negedge clk);
            tests_run++; if (gnt !== 4'b1000) begin tests_failed++; $display("FAIL steady_gnt c=%0d got %b exp 1000", c, gnt); end
            if (c >= 10) begin
                tests_run++; if (inflight !== CNT_W'(LAT + 2)) begin tests_failed++; $display("FAIL steady_inflight c=%0d got %0d exp %0d", c, inflight, LAT + 2); end
                tests_run++; if (rsp_valid !== 4'b1000 || rsp_data !== THREE) begin tests_failed++; $display("FAIL steady_rsp c=%0d got %b/%h exp 1000/%h", c, rsp_valid, rsp_data, THREE); end
            end
            tick();
        end
        req = '0;
        repeat (12) tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        opa_in[1*W +: W] = ONE;
        opb_in[1*W +: W] = ONE;
        for (int c = 0; c < 3; c++) begin
            req = 4'b0010;
            @(negedge clk);
            tests_run++; if (gnt !== 4'b0010) begin tests_failed++; $display("FAIL midflight_issue c=%0d got %b exp 0010", c, gnt); end
            tick();
        end
        req = '0;
        repeat (2) tick();
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        tests_run++; if (gnt !== 4'b0000 || inflight !== '0) begin tests_failed++; $display("FAIL midflight_in_reset got gnt=%b inflight=%0d exp 0000/0", gnt, inflight); end
        repeat (2) tick();
        rst = 1'b1;
        req = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests_run++; if (rsp_valid !== 4'b0000 || inflight !== '0) begin tests_failed++; $display("FAIL midflight_quiet c=%0d got rsp=%b inflight=%0d exp 0000/0", c, rsp_valid, inflight); end
            tick();
        end
        req = 4'b1111;
        @(negedge clk);
        tests_run++; if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL midflight_next_gnt got %b exp 0001", gnt); end
        tick();
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_throughput();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
